// File: rtl/pipe_result_divider.sv
// pipe_result_divider: iterative unsigned restoring divider (Q = F / D, R = F % D) with valid/ready input and one-cycle result strobe.
module pipe_result_divider #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] F,
  input  logic [N-1:0] D,
  output logic         out_valid,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         dz
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [N-1:0] qsh, dsr, rem;
  logic [CW-1:0] cnt;
  logic [N:0] rem_sh;
  logic ge;
  logic [N-1:0] rem_nx, qsh_nx;
  // The partial remainder never reaches D, so its stored form fits in N bits; the shifted value needs N+1.
  assign rem_sh = {rem, qsh[N-1]};
  assign ge = rem_sh >= {1'b0, dsr};
  assign rem_nx = ge ? N'(rem_sh - {1'b0, dsr}) : rem_sh[N-1:0];
  assign qsh_nx = {qsh[N-2:0], ge};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      Q <= '0;
      R <= '0;
      dz <= 1'b0;
      qsh <= '0;
      dsr <= '0;
      rem <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (in_valid) begin
            qsh <= F;
            dsr <= D;
            rem <= '0;
            cnt <= '0;
            in_ready <= 1'b0;
            if (D == '0) begin
              state <= DONE;
              out_valid <= 1'b1;
              Q <= '1;
              R <= F;
              dz <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          qsh <= qsh_nx;
          rem <= rem_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            state <= DONE;
            out_valid <= 1'b1;
            Q <= qsh_nx;
            R <= rem_nx;
            dz <= 1'b0;
          end
        end
        DONE: begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
